// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
// Data-memory responder for a single-cycle core. It holds word-organised RAM
// with byte-lane writes and a small peripheral window. The window contains a
// console TX FIFO, a free-running 64-bit cycle counter and a 64-bit compare
// timer. Reads are combinational; all state changes on the rising clock edge.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   daddr      byte address from the CPU
//   dwdata     write data from the CPU
//   we         per-byte write enables, bit i covers dwdata[8i+7:8i]
//   drdata     read data, combinational from daddr and current state
//   tx_data    FIFO head byte
//   tx_valid   FIFO non-empty
//   tx_ready   consumer takes the head byte this cycle
//   irq_timer  timer pending flag
//
// Peripheral map (word offset daddr[7:2] inside the window)
//   0x00 TXDATA    write pushes dwdata[7:0] when we[0]=1; reads 0
//   0x04 STATUS    {pending, overflow, full, empty}; bits 3:2 are write-1-to-clear
//   0x08 CYCLE_LO  counter bits 31:0, read-only
//   0x0C CYCLE_HI  counter bits 63:32, read-only
//   0x10 CMP_LO    compare bits 31:0, byte-enabled RW
//   0x14 CMP_HI    compare bits 63:32, byte-enabled RW
module dmem_mmio_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  we,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq_timer
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int FW = $clog2(FIFO_DEPTH);

   localparam logic [5:0] OFF_TXDATA = 6'h00;
   localparam logic [5:0] OFF_STATUS = 6'h01;
   localparam logic [5:0] OFF_CYC_LO = 6'h02;
   localparam logic [5:0] OFF_CYC_HI = 6'h03;
   localparam logic [5:0] OFF_CMP_LO = 6'h04;
   localparam logic [5:0] OFF_CMP_HI = 6'h05;

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [7:0]  r_fifo [FIFO_DEPTH];
   logic [FW:0] r_wr_ptr;
   logic [FW:0] r_rd_ptr;
   logic        r_overflow;
   logic        r_pending;
   logic [63:0] r_cycle;
   logic [63:0] r_cmp;

   logic          w_is_mmio;
   logic          w_is_ram;
   logic [AW-1:0] w_ram_idx;
   logic [5:0]    w_off;
   logic          w_mmio_wr;
   logic          w_empty;
   logic          w_full;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_status_wr;
   logic          w_clr_ovf;
   logic          w_clr_pend;
   logic          w_cmp_lo_wr;
   logic          w_cmp_hi_wr;
   logic          w_unused;

   // Peripheral window wins; RAM only below DEPTH_WORDS words, so nothing aliases.
   assign w_is_mmio = (daddr[31:16] == MMIO_BASE[31:16]);
   assign w_is_ram  = !w_is_mmio && (daddr[31:AW+2] == '0);
   assign w_ram_idx = daddr[AW+1:2];
   assign w_off     = daddr[7:2];
   assign w_mmio_wr = w_is_mmio && (we != 4'b0000);
   assign w_unused  = ^daddr[1:0];

   // Pointers carry a wrap bit: equal means empty, equal except wrap bit means full.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[FW] != r_rd_ptr[FW]) &&
                    (r_wr_ptr[FW-1:0] == r_rd_ptr[FW-1:0]);

   // Full is judged before this cycle's pop, so a push on a full FIFO drops
   // even when the consumer frees an entry at the same edge.
   assign w_push_req = w_mmio_wr && (w_off == OFF_TXDATA) && we[0];
   assign w_push     = w_push_req && !w_full;
   assign w_pop      = !w_empty && tx_ready;

   assign w_status_wr = w_mmio_wr && (w_off == OFF_STATUS);
   assign w_clr_ovf   = w_status_wr && dwdata[2];
   assign w_clr_pend  = w_status_wr && dwdata[3];
   assign w_cmp_lo_wr = w_is_mmio && (w_off == OFF_CMP_LO);
   assign w_cmp_hi_wr = w_is_mmio && (w_off == OFF_CMP_HI);

   assign tx_data   = r_fifo[r_rd_ptr[FW-1:0]];
   assign tx_valid  = !w_empty;
   assign irq_timer = r_pending;

   // RAM and FIFO storage carry no reset; only the control state is cleared.
   always_ff @(posedge clk) begin
      if (w_is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) r_mem[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr[FW-1:0]] <= dwdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
         r_pending  <= 1'b0;
         r_cycle    <= '0;
         r_cmp      <= '1;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

         // A drop in the same cycle as a clear keeps the flag: the new event is not lost.
         if (w_push_req && w_full) r_overflow <= 1'b1;
         else if (w_clr_ovf)       r_overflow <= 1'b0;

         // Software clear wins; a still-true compare re-arms on the next edge.
         if (w_clr_pend)            r_pending <= 1'b0;
         else if (r_cycle >= r_cmp) r_pending <= 1'b1;

         for (int i = 0; i < 4; i++) begin
            if (w_cmp_lo_wr && we[i]) r_cmp[8*i +: 8]      <= dwdata[8*i +: 8];
            if (w_cmp_hi_wr && we[i]) r_cmp[32 + 8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      drdata = '0;
      if (w_is_mmio) begin
         case (w_off)
            OFF_STATUS: drdata = {28'b0, r_pending, r_overflow, w_full, w_empty};
            OFF_CYC_LO: drdata = r_cycle[31:0];
            OFF_CYC_HI: drdata = r_cycle[63:32];
            OFF_CMP_LO: drdata = r_cmp[31:0];
            OFF_CMP_HI: drdata = r_cmp[63:32];
            default:    drdata = '0;
         endcase
      end else if (w_is_ram) begin
         drdata = r_mem[w_ram_idx];
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

   localparam logic [31:0] MB        = 32'hFFFF_0000;
   localparam logic [31:0] A_TXDATA  = MB | 32'h00;
   localparam logic [31:0] A_STATUS  = MB | 32'h04;
   localparam logic [31:0] A_CYC_LO  = MB | 32'h08;
   localparam logic [31:0] A_CYC_HI  = MB | 32'h0C;
   localparam logic [31:0] A_CMP_LO  = MB | 32'h10;
   localparam logic [31:0] A_CMP_HI  = MB | 32'h14;
   localparam int          FDEPTH    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dwdata = '0;
   logic [3:0]  we = '0;
   logic        tx_ready = 1'b0;
   logic [31:0] drdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        irq_timer;

   int checks = 0;
   int failures = 0;
   logic [7:0] q[$];

   dmem_mmio_responder #(
      .DEPTH_WORDS(1024),
      .MMIO_BASE(32'hFFFF_0000),
      .FIFO_DEPTH(FDEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .daddr(daddr),
      .dwdata(dwdata),
      .we(we),
      .drdata(drdata),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .irq_timer(irq_timer)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
      daddr = a; dwdata = d; we = e;
      tick();
      we = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      daddr = a; we = '0;
      #1;
      d = drdata;
   endtask

   task automatic do_reset();
      rst = 1'b1; we = '0;
      tick();
      rst = 1'b0;
      q.delete();
   endtask

   // One bus cycle with optional TXDATA push; the queue is the expected FIFO content.
   task automatic step(input bit push, input logic [7:0] b, input bit ready);
      bit full;
      tx_ready = ready;
      daddr = A_TXDATA; dwdata = {24'h0, b}; we = push ? 4'h1 : 4'h0;
      #1;
      checks++;
      if (tx_valid !== (q.size() != 0)) begin
         $display("FAIL fifo_valid got=%b exp=%b", tx_valid, q.size() != 0);
         failures++;
      end
      full = (q.size() == FDEPTH);
      if (q.size() != 0) begin
         checks++;
         if (tx_data !== q[0]) begin
            $display("FAIL fifo_head got=%h exp=%h", tx_data, q[0]);
            failures++;
         end
         if (ready) void'(q.pop_front());
      end
      if (push && !full) q.push_back(b);
      tick();
      we = '0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      q.delete();
      rd(A_CYC_LO, v);
      checks++; if (v !== 32'd0) begin $display("FAIL rst_cycle_lo got=%h exp=0", v); failures++; end
      rd(A_STATUS, v);
      checks++; if (v !== 32'h1) begin $display("FAIL rst_status got=%h exp=1", v); failures++; end
      checks++; if (tx_valid !== 1'b0 || irq_timer !== 1'b0) begin
         $display("FAIL rst_outputs got=%b%b exp=00", tx_valid, irq_timer); failures++; end
      rd(A_CMP_LO, v);
      checks++; if (v !== 32'hFFFF_FFFF) begin $display("FAIL rst_cmp_lo got=%h exp=ffffffff", v); failures++; end
      tick();
      rd(A_CMP_HI, v);
      checks++; if (v !== 32'hFFFF_FFFF) begin $display("FAIL rst_cmp_hi got=%h exp=ffffffff", v); failures++; end
      rd(A_CYC_LO, v);
      checks++; if (v !== 32'd1) begin $display("FAIL rst_cycle_step got=%h exp=1", v); failures++; end
   endtask

   task automatic test_ram();
      logic [31:0] v;
      wr(32'h10, 32'hAABB_CCDD, 4'hF);
      daddr = 32'h10; dwdata = 32'h0000_1100; we = 4'h2;
      #1;
      checks++; if (drdata !== 32'hAABB_CCDD) begin
         $display("FAIL ram_read_during_write got=%h exp=aabbccdd", drdata); failures++; end
      tick();
      we = '0;
      rd(32'h10, v);
      checks++; if (v !== 32'hAABB_11DD) begin $display("FAIL ram_byte_lane got=%h exp=aabb11dd", v); failures++; end
      rd(32'h13, v);
      checks++; if (v !== 32'hAABB_11DD) begin $display("FAIL ram_unaligned got=%h exp=aabb11dd", v); failures++; end
   endtask

   task automatic test_fifo();
      logic [31:0] v;
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h6) begin $display("FAIL fifo_full_status got=%h exp=6", v); failures++; end
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      tx_ready = 1'b0;
      rd(A_STATUS, v);
      checks++; if (v !== 32'h5) begin $display("FAIL fifo_drained_status got=%h exp=5", v); failures++; end
      wr(A_STATUS, 32'h4, 4'h1);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h1) begin $display("FAIL fifo_ovf_clear got=%h exp=1", v); failures++; end
      rd(A_TXDATA, v);
      checks++; if (v !== 32'h0) begin $display("FAIL txdata_read got=%h exp=0", v); failures++; end
   endtask

   task automatic test_simul();
      logic [31:0] v;
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
      step(1'b1, 8'h5A, 1'b1);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h0) begin $display("FAIL simul_status got=%h exp=0", v); failures++; end
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      step(1'b1, 8'h70, 1'b1);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h4) begin $display("FAIL full_push_pop_status got=%h exp=4", v); failures++; end
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
      tx_ready = 1'b0;
      wr(A_STATUS, 32'h4, 4'h1);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h1) begin $display("FAIL simul_clear got=%h exp=1", v); failures++; end
   endtask

   task automatic test_unmapped();
      logic [31:0] v;
      wr(32'h0, 32'h1234_5678, 4'hF);
      wr(32'h1000, 32'hDEAD_BEEF, 4'hF);
      rd(32'h1000, v);
      checks++; if (v !== 32'h0) begin $display("FAIL unmapped_read got=%h exp=0", v); failures++; end
      rd(32'h0, v);
      checks++; if (v !== 32'h1234_5678) begin $display("FAIL no_alias got=%h exp=12345678", v); failures++; end
      rd(MB | 32'h40, v);
      checks++; if (v !== 32'h0) begin $display("FAIL mmio_hole got=%h exp=0", v); failures++; end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      bit found;
      do_reset();
      wr(A_CMP_HI, 32'h0, 4'hF);
      wr(A_CMP_LO, 32'd100, 4'hF);
      found = 1'b0;
      for (int n = 0; n < 300; n++) begin
         rd(A_CYC_LO, v);
         if (v == 32'd100) begin found = 1'b1; break; end
         tick();
      end
      checks++; if (!found) begin $display("FAIL timer_wait got=%0d exp=100", v); failures++; end
      checks++; if (irq_timer !== 1'b0) begin $display("FAIL irq_early got=%b exp=0", irq_timer); failures++; end
      rd(A_CYC_HI, v);
      checks++; if (v !== 32'h0) begin $display("FAIL cycle_hi got=%h exp=0", v); failures++; end
      tick();
      checks++; if (irq_timer !== 1'b1) begin $display("FAIL irq_rise got=%b exp=1", irq_timer); failures++; end
      wr(A_STATUS, 32'h8, 4'h1);
      checks++; if (irq_timer !== 1'b0) begin $display("FAIL irq_w1c got=%b exp=0", irq_timer); failures++; end
      tick();
      checks++; if (irq_timer !== 1'b1) begin $display("FAIL irq_rearm got=%b exp=1", irq_timer); failures++; end
      wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
      wr(A_CMP_HI, 32'hFFFF_FFFF, 4'hF);
      rd(A_STATUS, v);
      checks++; if (v !== 32'h9) begin $display("FAIL status_pending got=%h exp=9", v); failures++; end
      wr(A_STATUS, 32'h8, 4'h1);
      repeat (5) tick();
      checks++; if (irq_timer !== 1'b0) begin $display("FAIL irq_stays_low got=%b exp=0", irq_timer); failures++; end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      bit found;
      do_reset();
      wr(A_CMP_HI, 32'h0, 4'hF);
      wr(A_CMP_LO, 32'd10, 4'hF);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      found = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         rd(A_CYC_LO, v);
         if (v >= 32'd500) begin found = 1'b1; break; end
         tick();
      end
      checks++; if (!found || irq_timer !== 1'b1 || tx_valid !== 1'b1) begin
         $display("FAIL mid_setup got=%b%b%b exp=111", found, irq_timer, tx_valid); failures++; end
      do_reset();
      checks++; if (tx_valid !== 1'b0 || irq_timer !== 1'b0) begin
         $display("FAIL mid_rst_outputs got=%b%b exp=00", tx_valid, irq_timer); failures++; end
      rd(A_STATUS, v);
      checks++; if (v !== 32'h1) begin $display("FAIL mid_rst_status got=%h exp=1", v); failures++; end
      rd(A_CYC_LO, v);
      checks++; if (v !== 32'h0) begin $display("FAIL mid_rst_cycle got=%h exp=0", v); failures++; end
      tick();
      rd(A_CYC_LO, v);
      checks++; if (v !== 32'h1) begin $display("FAIL mid_rst_cycle_step got=%h exp=1", v); failures++; end
      rd(32'h10, v);
      checks++; if (v !== 32'hAABB_11DD) begin $display("FAIL ram_retained got=%h exp=aabb11dd", v); failures++; end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_fifo();
      test_simul();
      test_unmapped();
      test_timer();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
